// File: rtl/nor_two_gate.sv
// nor_two_gate: two-input NOR leaf cell with clocked diagnostics.
//
// Ports:
//   clk      - single clock, all state updates on its rising edge
//   rst_n    - asynchronous active-low reset
//   A, B     - NOR operands
//   clr      - synchronous clear of rise_cnt and seen (wins over updates)
//   y        - combinational ~(A | B)
//   y_q      - y registered on clk
//   rise_cnt - saturating count of 0->1 transitions of y_q
//   seen     - input combinations sampled since reset/clear, bit index {A,B}
//   all_seen - high when every combination has been sampled
//
// Build option: define NOR_TWO_GATE_COVER_EN to build the seen/all_seen
// coverage tracking; otherwise seen is tied to 0 and all_seen to 0.

module nor_two_gate #(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             A,
  input  logic             B,
  input  logic             clr,
  output logic             y,
  output logic             y_q,
  output logic [CNT_W-1:0] rise_cnt,
  output logic [3:0]       seen,
  output logic             all_seen
);

  logic             y_reg_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  assign y = ~(A | B);

  // A rise is seen when the registered value is about to go 0 -> 1.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (!y_reg_q && y && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y_reg_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      y_reg_q <= y;
      cnt_q   <= cnt_d;
    end
  end

  assign y_q      = y_reg_q;
  assign rise_cnt = cnt_q;

`ifdef NOR_TWO_GATE_COVER_EN
  logic [3:0] seen_q;
  logic [3:0] seen_d;

  always_comb begin
    seen_d = seen_q;
    if (clr) begin
      seen_d = 4'b0000;
    end else begin
      seen_d[{A, B}] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seen_q <= 4'b0000;
    end else begin
      seen_q <= seen_d;
    end
  end

  assign seen = seen_q;
`else
  assign seen = 4'b0000;
`endif

  assign all_seen = &seen;

endmodule

// File: tb/tb_nor_two_gate.sv
// Testbench for nor_two_gate (CNT_W = 7). A behavioural model tracks the
// expected y_q, rise count and coverage set; a negedge process compares the
// DUT against it every cycle, and directed points check literal values.

module tb_nor_two_gate;

  localparam int unsigned CNT_W = 7;
  localparam int          MAX   = (1 << CNT_W) - 1;

  logic             clk;
  logic             rst_n;
  logic             A;
  logic             B;
  logic             clr;
  logic             y;
  logic             y_q;
  logic [CNT_W-1:0] rise_cnt;
  logic [3:0]       seen;
  logic             all_seen;

  bit clk_en;
  int n_cmp;
  int n_bad;

  // NOR truth table, indexed by {A,B}.
  bit tt [0:3] = '{1'b1, 1'b0, 1'b0, 1'b0};

  // Model state.
  bit   m_yq;
  int   m_cnt;
  bit   m_seen [0:3];

  nor_two_gate #(
    .CNT_W(CNT_W)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .A       (A),
    .B       (B),
    .clr     (clr),
    .y       (y),
    .y_q     (y_q),
    .rise_cnt(rise_cnt),
    .seen    (seen),
    .all_seen(all_seen)
  );

  initial begin
    clk = 1'b0;
    forever begin
      #5;
      if (clk_en) clk = ~clk;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [3:0] exp_seen();
    logic [3:0] s;
    s = 4'b0000;
`ifdef NOR_TWO_GATE_COVER_EN
    for (int i = 0; i < 4; i++) s[i] = m_seen[i];
`endif
    return s;
  endfunction

  // Behavioural model: y_q follows the table, rises counted up to MAX.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_yq  <= 1'b0;
      m_cnt <= 0;
      for (int i = 0; i < 4; i++) m_seen[i] <= 1'b0;
    end else begin
      m_yq <= tt[{A, B}];
      if (clr) begin
        m_cnt <= 0;
        for (int i = 0; i < 4; i++) m_seen[i] <= 1'b0;
      end else begin
        if (!m_yq && tt[{A, B}]) m_cnt <= (m_cnt < MAX) ? m_cnt + 1 : MAX;
        m_seen[{A, B}] <= 1'b1;
      end
    end
  end

  always @(negedge clk) begin
    check("y", {31'd0, y}, {31'd0, tt[{A, B}]});
    check("y_q", {31'd0, y_q}, {31'd0, m_yq});
    check("rise_cnt", {25'd0, rise_cnt}, m_cnt);
    check("seen", {28'd0, seen}, {28'd0, exp_seen()});
    check("all_seen", {31'd0, all_seen}, {31'd0, (exp_seen() == 4'hf)});
  end

  task automatic cyc(input logic a, input logic b, input logic c);
    A   = a;
    B   = b;
    clr = c;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic [1:0] ab;
    bit         exp_y [0:3];
    n_cmp  = 0;
    n_bad  = 0;
    clk_en = 1'b0;
    rst_n  = 1'b0;
    A      = 1'b0;
    B      = 1'b0;
    clr    = 1'b0;
    exp_y  = '{1'b1, 1'b0, 1'b0, 1'b0};

    // Combinational sweep with no clock, held in reset.
    for (int i = 0; i < 4; i++) begin
      ab = i[1:0];
      A  = ab[1];
      B  = ab[0];
      #100;
      check("comb_y", {31'd0, y}, {31'd0, exp_y[i]});
    end
    check("rst_y_q", {31'd0, y_q}, 32'd0);
    check("rst_cnt", {25'd0, rise_cnt}, 32'd0);
    check("rst_seen", {28'd0, seen}, 32'd0);
    check("rst_all_seen", {31'd0, all_seen}, 32'd0);

    // Clocked sweep 00, 01, 10, 11.
    A      = 1'b0;
    B      = 1'b0;
    clk_en = 1'b1;
    #12;
    rst_n  = 1'b1;
    #3;
    cyc(1'b0, 1'b0, 1'b0);
    check("sweep_yq0", {31'd0, y_q}, 32'd1);
    check("sweep_cnt0", {25'd0, rise_cnt}, 32'd1);
    cyc(1'b0, 1'b1, 1'b0);
    check("sweep_yq1", {31'd0, y_q}, 32'd0);
    cyc(1'b1, 1'b0, 1'b0);
    check("sweep_yq2", {31'd0, y_q}, 32'd0);
    cyc(1'b1, 1'b1, 1'b0);
    check("sweep_yq3", {31'd0, y_q}, 32'd0);
    check("sweep_cnt", {25'd0, rise_cnt}, 32'd1);
`ifdef NOR_TWO_GATE_COVER_EN
    check("sweep_seen", {28'd0, seen}, 32'hf);
    check("sweep_all_seen", {31'd0, all_seen}, 32'd1);
`else
    check("sweep_seen", {28'd0, seen}, 32'h0);
    check("sweep_all_seen", {31'd0, all_seen}, 32'd0);
`endif

    // Clear on the same edge that y_q rises.
    cyc(1'b1, 1'b1, 1'b0);
    cyc(1'b0, 1'b0, 1'b1);
    check("clr_cnt", {25'd0, rise_cnt}, 32'd0);
    check("clr_seen", {28'd0, seen}, 32'd0);
    check("clr_yq", {31'd0, y_q}, 32'd1);
    clr = 1'b0;

    // 300 cycles toggling 11/00: 150 rises saturate at 127.
    for (int i = 0; i < 300; i++) begin
      if (i % 2 == 0) cyc(1'b1, 1'b1, 1'b0);
      else            cyc(1'b0, 1'b0, 1'b0);
    end
    check("sat_cnt", {25'd0, rise_cnt}, 32'd127);
    cyc(1'b1, 1'b1, 1'b0);
    cyc(1'b0, 1'b0, 1'b0);
    check("sat_hold", {25'd0, rise_cnt}, 32'd127);

    // Asynchronous reset between edges.
    cyc(1'b0, 1'b1, 1'b0);
    cyc(1'b0, 1'b0, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_yq", {31'd0, y_q}, 32'd0);
    check("arst_cnt", {25'd0, rise_cnt}, 32'd0);
    check("arst_seen", {28'd0, seen}, 32'd0);
    check("arst_all_seen", {31'd0, all_seen}, 32'd0);
    check("arst_y00", {31'd0, y}, 32'd1);
    #2;
    A = 1'b1;
    #1;
    check("arst_y10", {31'd0, y}, 32'd0);
    A = 1'b0;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("post_rst_yq", {31'd0, y_q}, 32'd1);
    check("post_rst_cnt", {25'd0, rise_cnt}, 32'd1);
    cyc(1'b1, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0);
    check("post_rst_cnt2", {25'd0, rise_cnt}, 32'd2);
    @(negedge clk);
    #1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/nor_two_gate.md
# nor_two_gate

Two-input NOR primitive with a registered copy of its output, a saturating rising-edge counter and truth-table input coverage tracking. It is the leaf logic cell of the gate-level library. The combinational output serves gate-level datapaths; the clocked side feeds self-test and diagnostics logic.

## Interface
Parameters:
- CNT_W, 8, width of the rising-edge counter (legal 1..32).

Ports:
- clk  input  1  single clock; all state updates on its rising edge.
- rst_n  input  1  reset; asynchronous, active-low.
- A  input  1  NOR operand A.
- B  input  1  NOR operand B.
- clr  input  1  synchronous clear of `rise_cnt` and `seen`.
- y  output  1  combinational ~(A | B).
- y_q  output  1  registered `y`.
- rise_cnt  output  CNT_W  count of 0->1 transitions of `y_q`.
- seen  output  4  input combinations sampled since reset or clear; bit index {A,B}.
- all_seen  output  1  high when seen == 4'b1111.

The clock and reset decision is fixed: one clock; reset is asynchronous and active-low.

## Operation
- `y` = ~(A | B) at all times, regardless of `clk`, `rst_n` or `clr`.
- Truth table for `y`:
  - 00 -> 1
  - 01 -> 0
  - 10 -> 0
  - 11 -> 0
- Each rising edge with rst_n=1 performs these updates:
  - `y_q` <= ~(A | B).
  - If `y_q`==0 and the new value is 1, `rise_cnt` increments by 1. It saturates at 2^CNT_W-1 and does not wrap.
  - `seen[{A,B}]` <= 1. Bits never self-clear.
- `clr`=1 at an edge:
  - `rise_cnt` is forced to 0 and `seen` to 4'b0000.
  - `clr` has priority over a simultaneous increment or seen-set at that edge.
  - `y_q` still samples normally.
- `all_seen` is combinational from `seen`.
- X/Z on A or B: `y` follows standard Verilog NOR semantics. No special handling is required.

## Timing
- `y`: zero-cycle, purely combinational.
- `y_q`: one-cycle latency from A/B.
- `rise_cnt` updates on the same edge that `y_q` rises. It is therefore visible in the same cycle as the new `y_q`.
- `seen` and `all_seen` are visible the cycle after the combination is sampled.
- Reset values, applied immediately on rst_n falling: y_q=0, rise_cnt=0, seen=0, all_seen=0.
- Reset mid-operation:
  - All registers clear asynchronously.
  - `y` is unaffected.
  - After release, the first edge samples normally. If A=B=0 at that edge, `y_q` 0->1 counts as a rise.
- Saturation boundary: at rise_cnt = 2^CNT_W-1, further rises leave it unchanged.

## Configuration
- NOR_TWO_GATE_COVER_EN:
  - Defined: `seen`/`all_seen` tracking is built as described.
  - Undefined: the `seen` registers are not synthesized. `seen` is tied to 4'b0000 and `all_seen` to 0.
  - `y`, `y_q`, `rise_cnt` and `clr` (for the counter) behave identically in both builds.

## Test plan
- Combinational sweep, each held 100 ns, no clock, rst_n=0:
  - AB=00 -> y=1
  - AB=01 -> y=0
  - AB=10 -> y=0
  - AB=11 -> y=0
- Clocked sweep after reset, one combination per cycle in order 00, 01, 10, 11:
  - y_q = 1, 0, 0, 0, each one cycle late.
  - rise_cnt=1.
  - seen=4'b1111 and all_seen=1 (COVER_EN defined).
- Toggle AB between 00 and 11 every cycle for 300 cycles with CNT_W=7 -> rise_cnt saturates at 127 and holds.
- Assert clr on the same edge where `y_q` rises -> rise_cnt=0, seen=0, y_q=1.
- Drop rst_n asynchronously mid-sweep, between edges -> y_q, rise_cnt, seen and all_seen read 0 immediately, while `y` still tracks A/B.
- Build without NOR_TWO_GATE_COVER_EN, full sweep -> seen=0, all_seen=0, rise_cnt identical to the covered build.
